// File: rtl/rtype_pkg.sv
// Shared encodings for the R-type execution core: opcode/func constants,
// FSM state type and the legal-function decode helper.
package rtype_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'd0;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_XOR = 6'd38;
    localparam logic [5:0] FN_SLT = 6'd42;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_ERR
    } state_t;

    function automatic logic func_legal(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_XOR) || (f == FN_SLT);
    endfunction

endpackage

// File: rtl/rtype_regfile.sv
// Register file: one synchronous write port, two combinational operand reads
// and a combinational debug read. Register 0 is a constant zero.
module rtype_regfile
    import rtype_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_rdata
);

    logic [DATA_W-1:0] mem [NREGS];

    assign mem[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_reg
            logic [DATA_W-1:0] q_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (we && (waddr == AW'(gi))) begin
                    q_reg <= wdata;
                end
            end
            assign mem[gi] = q_reg;
        end
    endgenerate

    assign rdata_a   = mem[raddr_a];
    assign rdata_b   = mem[raddr_b];
    assign dbg_rdata = mem[dbg_addr];

endmodule

// File: rtl/rtype_core.sv
// Multi-cycle R-type execution core: IDLE -> DECODE -> EXEC -> WB (or ERR),
// with an idle-time register load port and a combinational register peek.
module rtype_core
    import rtype_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       inst,
    input  logic              inst_valid,
    output logic              inst_ready,
    output logic              done,
    output logic              err,
    output logic              ovf,
    output logic [AW-1:0]     wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic              dbg_we,
    input  logic [AW-1:0]     dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata
);

    state_t            state_reg;
    logic [5:0]        op_reg;
    logic [4:0]        rs_reg;
    logic [4:0]        rt_reg;
    logic [4:0]        rd_reg;
    logic [5:0]        func_reg;
    logic [DATA_W-1:0] opa_reg;
    logic [DATA_W-1:0] opb_reg;
    logic              inst_ready_reg;
    logic              done_reg;
    logic              err_reg;
    logic              ovf_reg;
    logic [AW-1:0]     wb_addr_reg;
    logic [DATA_W-1:0] wb_data_reg;

    // The shamt field has no meaning for the supported functions.
    logic unused_shamt;
    assign unused_shamt = ^inst[10:6];

    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;

    rtype_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (rf_we),
        .waddr     (rf_waddr),
        .wdata     (rf_wdata),
        .raddr_a   (rs_reg[AW-1:0]),
        .rdata_a   (rdata_a),
        .raddr_b   (rt_reg[AW-1:0]),
        .rdata_b   (rdata_b),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    // The only two writers are mutually exclusive by state.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = dbg_addr;
        rf_wdata = dbg_wdata;
        if (state_reg == ST_WB) begin
            rf_we    = 1'b1;
            rf_waddr = wb_addr_reg;
            rf_wdata = wb_data_reg;
        end else if (state_reg == ST_IDLE && dbg_we) begin
            rf_we = 1'b1;
        end
    end

    logic legal;
    always_comb begin
        legal = (op_reg == OPC_RTYPE) && func_legal(func_reg) &&
                ((rs_reg >> AW) == 5'd0) &&
                ((rt_reg >> AW) == 5'd0) &&
                ((rd_reg >> AW) == 5'd0);
    end

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;

    always_comb begin
        sum     = opa_reg + opb_reg;
        diff    = opa_reg - opb_reg;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (func_reg)
            FN_ADD: begin
                alu_res = sum;
                alu_ovf = (opa_reg[DATA_W-1] == opb_reg[DATA_W-1]) &&
                          (sum[DATA_W-1] != opa_reg[DATA_W-1]);
            end
            FN_SUB: begin
                alu_res = diff;
                alu_ovf = (opa_reg[DATA_W-1] != opb_reg[DATA_W-1]) &&
                          (diff[DATA_W-1] != opa_reg[DATA_W-1]);
            end
            FN_AND:  alu_res = opa_reg & opb_reg;
            FN_OR:   alu_res = opa_reg | opb_reg;
            FN_XOR:  alu_res = opa_reg ^ opb_reg;
            FN_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa_reg) < $signed(opb_reg))};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            op_reg         <= '0;
            rs_reg         <= '0;
            rt_reg         <= '0;
            rd_reg         <= '0;
            func_reg       <= '0;
            opa_reg        <= '0;
            opb_reg        <= '0;
            inst_ready_reg <= 1'b1;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            ovf_reg        <= 1'b0;
            wb_addr_reg    <= '0;
            wb_data_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (inst_valid) begin
                        op_reg         <= inst[31:26];
                        rs_reg         <= inst[25:21];
                        rt_reg         <= inst[20:16];
                        rd_reg         <= inst[15:11];
                        func_reg       <= inst[5:0];
                        inst_ready_reg <= 1'b0;
                        state_reg      <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (legal) begin
                        opa_reg   <= rdata_a;
                        opb_reg   <= rdata_b;
                        state_reg <= ST_EXEC;
                    end else begin
                        err_reg   <= 1'b1;
                        state_reg <= ST_ERR;
                    end
                end
                ST_EXEC: begin
                    wb_data_reg <= alu_res;
                    ovf_reg     <= alu_ovf;
                    wb_addr_reg <= rd_reg[AW-1:0];
                    done_reg    <= 1'b1;
                    state_reg   <= ST_WB;
                end
                ST_WB, ST_ERR: begin
                    inst_ready_reg <= 1'b1;
                    state_reg      <= ST_IDLE;
                end
                default: begin
                    inst_ready_reg <= 1'b1;
                    state_reg      <= ST_IDLE;
                end
            endcase
        end
    end

    assign inst_ready = inst_ready_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign ovf        = ovf_reg;
    assign wb_addr    = wb_addr_reg;
    assign wb_data    = wb_data_reg;

endmodule

// File: tb/tb_rtype_core.sv
// Directed bench for rtype_core (DATA_W=8, NREGS=16) with hand-computed
// expected values checked by immediate assertions.
module tb_rtype_core;

    localparam int DATA_W = 8;
    localparam int NREGS  = 16;
    localparam int AW     = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       inst = '0;
    logic              inst_valid = 1'b0;
    logic              inst_ready;
    logic              done;
    logic              err;
    logic              ovf;
    logic [AW-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              dbg_we = 1'b0;
    logic [AW-1:0]     dbg_addr = '0;
    logic [DATA_W-1:0] dbg_wdata = '0;
    logic [DATA_W-1:0] dbg_rdata;

    int vectors = 0;
    int miscompares = 0;

    rtype_core #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .done       (done),
        .err        (err),
        .ovf        (ovf),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_rdata  (dbg_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [5:0] fn);
        return {op, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic load(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
        dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
        step();
        dbg_we = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [AW-1:0] a, input logic [DATA_W-1:0] exp);
        dbg_addr = a;
        #1;
        check(tag, 32'(dbg_rdata), 32'(exp));
    endtask

    // Issues one instruction from IDLE and checks the cycle-by-cycle handshake.
    task automatic run_inst(input string tag, input logic [31:0] word, input bit legal,
                            input logic [AW-1:0] eaddr, input logic [DATA_W-1:0] edata,
                            input bit eovf);
        check({tag, "_ready_c0"}, 32'(inst_ready), 32'd1);
        inst = word; inst_valid = 1'b1;
        step();
        inst_valid = 1'b0; inst = '0; dbg_we = 1'b0;
        check({tag, "_ready_c1"}, 32'(inst_ready), 32'd0);
        check({tag, "_err_c1"}, 32'(err), 32'd0);
        step();
        check({tag, "_err_c2"}, 32'(err), 32'(!legal));
        check({tag, "_done_c2"}, 32'(done), 32'd0);
        step();
        check({tag, "_done_c3"}, 32'(done), 32'(legal));
        check({tag, "_err_c3"}, 32'(err), 32'd0);
        check({tag, "_ready_c3"}, 32'(inst_ready), 32'(!legal));
        if (legal) begin
            check({tag, "_wbaddr"}, 32'(wb_addr), 32'(eaddr));
            check({tag, "_wbdata"}, 32'(wb_data), 32'(edata));
            check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
            step();
            check({tag, "_ready_c4"}, 32'(inst_ready), 32'd1);
            check({tag, "_done_c4"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(inst_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_wbaddr", 32'(wb_addr), 32'd0);
        check("rst_wbdata", 32'(wb_data), 32'd0);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < NREGS; i++) peek($sformatf("rst_r%0d", i), AW'(i), 8'h00);

        load(4'd0, 8'hAA);
        peek("r0_load_ignored", 4'd0, 8'h00);
        load(4'd1, 8'h05);
        load(4'd2, 8'h03);
        peek("load_r1", 4'd1, 8'h05);
        peek("load_r2", 4'd2, 8'h03);

        run_inst("add", mk(6'd0, 5'd1, 5'd2, 5'd3, 6'd32), 1'b1, 4'd3, 8'h08, 1'b0);
        peek("add_r3", 4'd3, 8'h08);

        load(4'd1, 8'h00); load(4'd2, 8'h01);
        run_inst("sub_wrap", mk(6'd0, 5'd1, 5'd2, 5'd4, 6'd34), 1'b1, 4'd4, 8'hFF, 1'b0);
        peek("sub_wrap_r4", 4'd4, 8'hFF);
        load(4'd1, 8'h80);
        run_inst("sub_ovf", mk(6'd0, 5'd1, 5'd2, 5'd4, 6'd34), 1'b1, 4'd4, 8'h7F, 1'b1);
        load(4'd1, 8'h7F);
        run_inst("add_ovf", mk(6'd0, 5'd1, 5'd2, 5'd5, 6'd32), 1'b1, 4'd5, 8'h80, 1'b1);

        load(4'd1, 8'hCA); load(4'd2, 8'h5C);
        run_inst("and", mk(6'd0, 5'd1, 5'd2, 5'd5, 6'd36), 1'b1, 4'd5, 8'h48, 1'b0);
        run_inst("or",  mk(6'd0, 5'd1, 5'd2, 5'd5, 6'd37), 1'b1, 4'd5, 8'hDE, 1'b0);
        run_inst("xor", mk(6'd0, 5'd1, 5'd2, 5'd5, 6'd38), 1'b1, 4'd5, 8'h96, 1'b0);
        peek("xor_r5", 4'd5, 8'h96);

        run_inst("ill_opc", mk(6'd2, 5'd1, 5'd2, 5'd3, 6'd32), 1'b0, 4'd0, 8'h00, 1'b0);
        run_inst("ill_func", mk(6'd0, 5'd1, 5'd2, 5'd3, 6'd0), 1'b0, 4'd0, 8'h00, 1'b0);
        run_inst("ill_rd16", mk(6'd0, 5'd1, 5'd2, 5'd16, 6'd32), 1'b0, 4'd0, 8'h00, 1'b0);
        run_inst("ill_rs17", mk(6'd0, 5'd17, 5'd2, 5'd3, 6'd32), 1'b0, 4'd0, 8'h00, 1'b0);
        peek("ill_r3_kept", 4'd3, 8'h08);
        peek("ill_r0_kept", 4'd0, 8'h00);

        run_inst("add_r0", mk(6'd0, 5'd1, 5'd2, 5'd0, 6'd32), 1'b1, 4'd0, 8'h26, 1'b0);
        peek("add_r0_stays0", 4'd0, 8'h00);

        load(4'd1, 8'hFE); load(4'd2, 8'h01);
        run_inst("slt_neg", mk(6'd0, 5'd1, 5'd2, 5'd6, 6'd42), 1'b1, 4'd6, 8'h01, 1'b0);
        peek("slt_r6", 4'd6, 8'h01);
        run_inst("slt_pos", mk(6'd0, 5'd2, 5'd1, 5'd6, 6'd42), 1'b1, 4'd6, 8'h00, 1'b0);

        // Load and handshake in the same idle cycle: operand sees the new value.
        load(4'd2, 8'h03);
        dbg_we = 1'b1; dbg_addr = 4'd1; dbg_wdata = 8'h09;
        run_inst("dbg_same_cycle", mk(6'd0, 5'd1, 5'd2, 5'd8, 6'd32), 1'b1, 4'd8, 8'h0C, 1'b0);

        // Back-to-back dependent ADDs with inst_valid held throughout.
        load(4'd1, 8'h02);
        inst = mk(6'd0, 5'd1, 5'd2, 5'd7, 6'd32); inst_valid = 1'b1;
        step();
        check("b2b_a_busy_c1", 32'(inst_ready), 32'd0);
        step();
        step();
        check("b2b_a_done", 32'(done), 32'd1);
        check("b2b_a_data", 32'(wb_data), 32'h05);
        step();
        check("b2b_ready_c4", 32'(inst_ready), 32'd1);
        inst = mk(6'd0, 5'd7, 5'd7, 5'd7, 6'd32);
        step();
        inst_valid = 1'b0;
        check("b2b_b_accepted", 32'(inst_ready), 32'd0);
        step();
        step();
        check("b2b_b_done", 32'(done), 32'd1);
        check("b2b_b_addr", 32'(wb_addr), 32'd7);
        check("b2b_b_data", 32'(wb_data), 32'h0A);
        step();
        peek("b2b_r7", 4'd7, 8'h0A);

        // Reset in EXEC aborts the instruction with no pulse and no write.
        load(4'd1, 8'h11);
        inst = mk(6'd0, 5'd1, 5'd2, 5'd9, 6'd32); inst_valid = 1'b1;
        step();
        inst_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(inst_ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        step();
        step();
        check("midrst_done_later", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < NREGS; i++) peek($sformatf("midrst_r%0d", i), AW'(i), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
